// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined multiplier between two requesters. An in-order tag FIFO
// routes each product to a credit-limited per-requester result FIFO.
module mult_arbiter #(
    parameter int unsigned WIDTH     = 256,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_DEPTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               r0_valid,
    output logic               r0_ready,
    input  logic [WIDTH-1:0]   r0_x,
    input  logic [WIDTH-1:0]   r0_y,
    output logic               r0_rsp_valid,
    input  logic               r0_rsp_ready,
    output logic [2*WIDTH-1:0] r0_p,
    input  logic               r1_valid,
    output logic               r1_ready,
    input  logic [WIDTH-1:0]   r1_x,
    input  logic [WIDTH-1:0]   r1_y,
    output logic               r1_rsp_valid,
    input  logic               r1_rsp_ready,
    output logic [2*WIDTH-1:0] r1_p,
    output logic               mul_in_valid,
    output logic [WIDTH-1:0]   mul_x,
    output logic [WIDTH-1:0]   mul_y,
    input  logic [2*WIDTH-1:0] mul_p,
    input  logic               mul_out_valid,
    output logic               busy,
    output logic               err_orphan
);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   TW      = $clog2(TAG_DEPTH);
    localparam logic [CW-1:0] CntMax  = CW'(DEPTH);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [TW:0]   TagFull = (TW + 1)'(TAG_DEPTH);
    localparam logic [TW:0]   TagOne  = (TW + 1)'(1);

    logic [1:0]         req_valid, rsp_ready, elig, grant, res_wr, res_rd;
    logic [WIDTH-1:0]   req_x [2];
    logic [WIDTH-1:0]   req_y [2];
    logic               tag_full, tag_empty, accept, win, ret_pop, ret_owner;

    logic [CW-1:0]      cnt_q [2], cnt_d [2];
    logic [CW-1:0]      res_cnt_q [2], res_cnt_d [2];
    logic [AW-1:0]      res_wp_q [2], res_wp_d [2], res_rp_q [2], res_rp_d [2];
    logic [2*WIDTH-1:0] res_mem_q [2][DEPTH];
    logic               tag_mem_q [TAG_DEPTH];
    logic [TW-1:0]      tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [TW:0]        tag_cnt_q, tag_cnt_d;
    logic               rr_q, rr_d;
    logic               mul_in_valid_q, mul_in_valid_d;
    logic [WIDTH-1:0]   mul_x_q, mul_x_d, mul_y_q, mul_y_d;
    logic               err_orphan_q, err_orphan_d;

    always_comb begin
        req_valid = {r1_valid, r0_valid};
        rsp_ready = {r1_rsp_ready, r0_rsp_ready};
        req_x[0]  = r0_x;
        req_x[1]  = r1_x;
        req_y[0]  = r0_y;
        req_y[1]  = r1_y;
        // A pop in the same cycle does not free a tag slot for the incoming request.
        tag_full  = (tag_cnt_q == TagFull);
        tag_empty = (tag_cnt_q == '0);
        for (int i = 0; i < 2; i++) begin
            elig[i]   = req_valid[i] && (cnt_q[i] < CntMax) && !tag_full && !reset;
            res_rd[i] = (res_cnt_q[i] != '0) && rsp_ready[i];
        end
        grant[0]  = elig[0] && (!elig[1] || !rr_q);
        grant[1]  = elig[1] && (!elig[0] || rr_q);
        accept    = |grant;
        win       = grant[1];
        ret_pop   = mul_out_valid && !tag_empty;
        ret_owner = tag_mem_q[tag_rp_q];
        res_wr[0] = ret_pop && !ret_owner;
        res_wr[1] = ret_pop && ret_owner;

        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !res_rd[i]) cnt_d[i] = cnt_q[i] + CntOne;
            else if (!grant[i] && res_rd[i]) cnt_d[i] = cnt_q[i] - CntOne;
            res_cnt_d[i] = res_cnt_q[i];
            if (res_wr[i] && !res_rd[i]) res_cnt_d[i] = res_cnt_q[i] + CntOne;
            else if (!res_wr[i] && res_rd[i]) res_cnt_d[i] = res_cnt_q[i] - CntOne;
            res_wp_d[i] = res_wr[i] ? res_wp_q[i] + AW'(1) : res_wp_q[i];
            res_rp_d[i] = res_rd[i] ? res_rp_q[i] + AW'(1) : res_rp_q[i];
        end

        tag_wp_d  = accept ? tag_wp_q + TW'(1) : tag_wp_q;
        tag_rp_d  = ret_pop ? tag_rp_q + TW'(1) : tag_rp_q;
        tag_cnt_d = tag_cnt_q;
        if (accept && !ret_pop) tag_cnt_d = tag_cnt_q + TagOne;
        else if (!accept && ret_pop) tag_cnt_d = tag_cnt_q - TagOne;

        // Pointer only moves after a grant, so idle cycles keep the current priority.
        rr_d           = grant[0] ? 1'b1 : (grant[1] ? 1'b0 : rr_q);
        mul_in_valid_d = accept;
        mul_x_d        = accept ? req_x[win] : mul_x_q;
        mul_y_d        = accept ? req_y[win] : mul_y_q;
        err_orphan_d   = err_orphan_q || (mul_out_valid && tag_empty);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]     <= '0;
                res_cnt_q[i] <= '0;
                res_wp_q[i]  <= '0;
                res_rp_q[i]  <= '0;
            end
            tag_wp_q       <= '0;
            tag_rp_q       <= '0;
            tag_cnt_q      <= '0;
            rr_q           <= 1'b0;
            mul_in_valid_q <= 1'b0;
            mul_x_q        <= '0;
            mul_y_q        <= '0;
            err_orphan_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]     <= cnt_d[i];
                res_cnt_q[i] <= res_cnt_d[i];
                res_wp_q[i]  <= res_wp_d[i];
                res_rp_q[i]  <= res_rp_d[i];
            end
            tag_wp_q       <= tag_wp_d;
            tag_rp_q       <= tag_rp_d;
            tag_cnt_q      <= tag_cnt_d;
            rr_q           <= rr_d;
            mul_in_valid_q <= mul_in_valid_d;
            mul_x_q        <= mul_x_d;
            mul_y_q        <= mul_y_d;
            err_orphan_q   <= err_orphan_d;
        end
    end

    // Storage arrays need no reset; occupancy is tracked by the pointers and counts above.
    always_ff @(posedge clock) begin
        if (accept) tag_mem_q[tag_wp_q] <= win;
        for (int i = 0; i < 2; i++) begin
            if (res_wr[i]) res_mem_q[i][res_wp_q[i]] <= mul_p;
        end
    end

    assign r0_ready     = grant[0];
    assign r1_ready     = grant[1];
    assign r0_rsp_valid = (res_cnt_q[0] != '0);
    assign r1_rsp_valid = (res_cnt_q[1] != '0);
    assign r0_p         = res_mem_q[0][res_rp_q[0]];
    assign r1_p         = res_mem_q[1][res_rp_q[1]];
    assign mul_in_valid = mul_in_valid_q;
    assign mul_x        = mul_x_q;
    assign mul_y        = mul_y_q;
    assign busy         = (cnt_q[0] != '0) || (cnt_q[1] != '0);
    assign err_orphan   = err_orphan_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: pipelined multiplier model plus a stubbed instance
// with a deep credit limit for tag-FIFO exhaustion.
module tb_mult_arbiter;
    localparam int unsigned W = 256;
    localparam int unsigned L = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
    logic           r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
    logic [W-1:0]   r0_x, r0_y, r1_x, r1_y, mul_x, mul_y;
    logic [2*W-1:0] r0_p, r1_p, mul_p;
    logic           mul_in_valid, mul_out_valid, busy, err_orphan, inj_valid;

    logic           b_r0_valid, b_r0_ready, b_r0_rsp_valid, b_r1_valid, b_r1_ready, b_r1_rsp_valid;
    logic           b_rsp_ready, b_mul_in_valid, b_out_valid, b_busy, b_err;
    logic [W-1:0]   b_mul_x, b_mul_y;
    logic [2*W-1:0] b_r0_p, b_r1_p, big_p;

    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] exp_q0[$], exp_q1[$], got_q0[$], got_q1[$];

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Multiplier model of latency L, sharing the DUT reset.
    logic           pv [L];
    logic [2*W-1:0] pp [L];
    always @(posedge clk) begin
        pv[0] <= reset ? 1'b0 : mul_in_valid;
        pp[0] <= prod(mul_x, mul_y);
        for (int i = 1; i < L; i++) begin
            pv[i] <= reset ? 1'b0 : pv[i-1];
            pp[i] <= pp[i-1];
        end
    end
    assign mul_out_valid = pv[L-1] | inj_valid;
    assign mul_p         = pp[L-1];

    // Scoreboard: expectations pushed at accept, observed products captured at rsp handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (r0_valid && r0_ready) exp_q0.push_back(prod(r0_x, r0_y));
            if (r1_valid && r1_ready) exp_q1.push_back(prod(r1_x, r1_y));
            if (r0_rsp_valid && r0_rsp_ready) got_q0.push_back(r0_p);
            if (r1_rsp_valid && r1_rsp_ready) got_q1.push_back(r1_p);
        end
    end

    mult_arbiter u_dut (
        .clock(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_x(r0_x), .r0_y(r0_y),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_p(r0_p),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_x(r1_x), .r1_y(r1_y),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_p(r1_p),
        .mul_in_valid(mul_in_valid), .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
        .mul_out_valid(mul_out_valid), .busy(busy), .err_orphan(err_orphan)
    );

    mult_arbiter #(.WIDTH(W), .DEPTH(32), .TAG_DEPTH(32)) u_big (
        .clock(clk), .reset(reset),
        .r0_valid(b_r0_valid), .r0_ready(b_r0_ready), .r0_x(r0_x), .r0_y(r0_y),
        .r0_rsp_valid(b_r0_rsp_valid), .r0_rsp_ready(b_rsp_ready), .r0_p(b_r0_p),
        .r1_valid(b_r1_valid), .r1_ready(b_r1_ready), .r1_x(r1_x), .r1_y(r1_y),
        .r1_rsp_valid(b_r1_rsp_valid), .r1_rsp_ready(b_rsp_ready), .r1_p(b_r1_p),
        .mul_in_valid(b_mul_in_valid), .mul_x(b_mul_x), .mul_y(b_mul_y), .mul_p(big_p),
        .mul_out_valid(b_out_valid), .busy(b_busy), .err_orphan(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_q0.delete(); exp_q1.delete(); got_q0.delete(); got_q1.delete();
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0; r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
        b_r0_valid = 1'b0; b_r1_valid = 1'b0; b_out_valid = 1'b0; inj_valid = 1'b0;
        tick();
        reset = 1'b0;
        flush();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, mul_in_valid, busy, err_orphan}
            !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0000000", {r0_ready, r1_ready, r0_rsp_valid,
                     r1_rsp_valid, mul_in_valid, busy, err_orphan});
        end
        total++;
        if (mul_x !== '0 || mul_y !== '0) begin
            bad++; $display("FAIL reset_operands got=%h/%h exp=0", mul_x, mul_y);
        end
    endtask

    task automatic test_single();
        int n;
        logic [2*W-1:0] g, e;
        do_reset();
        r0_valid = 1'b1; r0_x = W'(3); r0_y = W'(5);
        @(negedge clk);
        total++;
        if (r0_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", r0_ready); end
        tick();
        r0_valid = 1'b0; r0_x = W'(7); r0_y = W'(9);
        n = 1;
        @(negedge clk);
        total++;
        if (mul_in_valid !== 1'b1 || mul_x !== W'(3) || mul_y !== W'(5)) begin
            bad++; $display("FAIL single_issue got=%b/%0d/%0d exp=1/3/5", mul_in_valid, mul_x, mul_y);
        end
        tick(); n++;
        @(negedge clk);
        total++;
        if (mul_in_valid !== 1'b0 || mul_x !== W'(3)) begin
            bad++; $display("FAIL single_hold got=%b/%0d exp=0/3", mul_in_valid, mul_x);
        end
        while (r0_rsp_valid !== 1'b1 && n < 20) begin
            tick(); n++;
            @(negedge clk);
        end
        total++;
        if (n != L + 2) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", n, L + 2); end
        total++;
        if (r0_p !== 512'd15) begin bad++; $display("FAIL single_p got=%0d exp=15", r0_p); end
        total++;
        if (r1_rsp_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL single_other got=%b/%b exp=0/1", r1_rsp_valid, busy);
        end
        tick(); r0_rsp_ready = 1'b1;
        tick(); r0_rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (r0_rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_drain got=%b/%b exp=0/0", r0_rsp_valid, busy);
        end
        total++;
        if (got_q0.size() != 1 || exp_q0.size() != 1) begin
            bad++; $display("FAIL single_count got=%0d exp=%0d", got_q0.size(), exp_q0.size());
        end else begin
            g = got_q0.pop_front(); e = exp_q0.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL single_sb got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_alternate();
        int n;
        logic [2*W-1:0] g, e;
        do_reset();
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r0_valid = 1'b1; r1_valid = 1'b1;
            r0_x = rnd(); r0_y = rnd(); r1_x = rnd(); r1_y = rnd();
            @(negedge clk);
            total++;
            if ({r0_ready, r1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL alt_grant cycle=%0d got=%b%b exp=%s", i, r0_ready, r1_ready,
                                (i % 2 == 0) ? "10" : "01");
            end
            tick();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        n = 0;
        while ((got_q0.size() < 4 || got_q1.size() < 4) && n < 50) begin tick(); n++; end
        total++;
        if (got_q0.size() != 4 || got_q1.size() != 4 || exp_q0.size() != 4 || exp_q1.size() != 4)
        begin
            bad++; $display("FAIL alt_count got=%0d/%0d exp=4/4", got_q0.size(), got_q1.size());
        end
        while (got_q0.size() > 0 && exp_q0.size() > 0) begin
            g = got_q0.pop_front(); e = exp_q0.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL alt_sb0 got=%h exp=%h", g, e); end
        end
        while (got_q1.size() > 0 && exp_q1.size() > 0) begin
            g = got_q1.pop_front(); e = exp_q1.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL alt_sb1 got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_credit();
        int a0, a1, n;
        logic [2*W-1:0] g, e;
        do_reset();
        r1_rsp_ready = 1'b1;
        a0 = 0; a1 = 0;
        for (int i = 0; i < 20; i++) begin
            r0_valid = 1'b1; r1_valid = 1'b1;
            r0_x = rnd(); r0_y = rnd(); r1_x = rnd(); r1_y = rnd();
            @(negedge clk);
            if (r0_ready) a0++;
            if (r1_ready) a1++;
            tick();
        end
        total++;
        if (a0 != 4) begin bad++; $display("FAIL credit_r0_accepts got=%0d exp=4", a0); end
        total++;
        if (a1 != 16) begin bad++; $display("FAIL credit_r1_accepts got=%0d exp=16", a1); end
        @(negedge clk);
        total++;
        if (r0_ready !== 1'b0) begin bad++; $display("FAIL credit_block got=%b exp=0", r0_ready); end
        tick();
        r0_rsp_ready = 1'b1;
        tick();
        r0_rsp_ready = 1'b0;
        a0 = 0;
        for (int i = 0; i < 10; i++) begin
            r0_x = rnd(); r0_y = rnd();
            @(negedge clk);
            if (r0_ready) a0++;
            tick();
        end
        total++;
        if (a0 != 1) begin bad++; $display("FAIL credit_refill got=%0d exp=1", a0); end
        r0_valid = 1'b0; r1_valid = 1'b0; r0_rsp_ready = 1'b1;
        n = 0;
        while ((got_q0.size() < exp_q0.size() || got_q1.size() < exp_q1.size()) && n < 50) begin
            tick(); n++;
        end
        total++;
        if (got_q0.size() != 5 || exp_q0.size() != 5 || got_q1.size() != exp_q1.size()) begin
            bad++; $display("FAIL credit_count got=%0d/%0d exp=5/%0d", got_q0.size(), got_q1.size(),
                            exp_q1.size());
        end
        while (got_q0.size() > 0 && exp_q0.size() > 0) begin
            g = got_q0.pop_front(); e = exp_q0.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL credit_sb0 got=%h exp=%h", g, e); end
        end
        while (got_q1.size() > 0 && exp_q1.size() > 0) begin
            g = got_q1.pop_front(); e = exp_q1.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL credit_sb1 got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_backpressure();
        int sent, cyc, stalls;
        logic prev_stall;
        logic [2*W-1:0] prev_p, g, e;
        do_reset();
        sent = 0; cyc = 0; stalls = 0; prev_stall = 1'b0; prev_p = '0;
        while ((sent < 50 || got_q0.size() < 50) && cyc < 1000) begin
            r0_valid = (sent < 50);
            r0_x = rnd(); r0_y = rnd();
            r0_rsp_ready = (cyc % 2 == 0);
            @(negedge clk);
            if (prev_stall) begin
                total++; stalls++;
                if (r0_p !== prev_p) begin
                    bad++; $display("FAIL bp_stable got=%h exp=%h", r0_p, prev_p);
                end
            end
            prev_stall = r0_rsp_valid && !r0_rsp_ready;
            prev_p = r0_p;
            if (r0_valid && r0_ready) sent++;
            tick(); cyc++;
        end
        r0_valid = 1'b0; r0_rsp_ready = 1'b0;
        total++;
        if (sent != 50 || stalls == 0) begin
            bad++; $display("FAIL bp_sent got=%0d stalls=%0d exp=50 stalls>0", sent, stalls);
        end
        total++;
        if (got_q0.size() != 50 || exp_q0.size() != 50) begin
            bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q0.size(), exp_q0.size());
        end
        while (got_q0.size() > 0 && exp_q0.size() > 0) begin
            g = got_q0.pop_front(); e = exp_q0.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL bp_sb got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        do_reset();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            r0_valid = 1'b1; r1_valid = 1'b1; r0_x = rnd(); r0_y = rnd(); r1_x = rnd(); r1_y = rnd();
            @(negedge clk);
            if (r0_ready || r1_ready) acc++;
            tick();
        end
        reset = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
        tick();
        reset = 1'b0;
        flush();
        @(negedge clk);
        total++;
        if (acc != 6 || {r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, busy, mul_in_valid} !== 6'b0)
        begin
            bad++; $display("FAIL midreset_clear got=%0d/%b exp=6/000000", acc, {r0_ready, r1_ready,
                            r0_rsp_valid, r1_rsp_valid, busy, mul_in_valid});
        end
        tick(); inj_valid = 1'b1;
        tick(); inj_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({err_orphan, r0_rsp_valid, r1_rsp_valid, busy} !== 4'b1000) begin
            bad++; $display("FAIL orphan_set got=%b exp=1000", {err_orphan, r0_rsp_valid,
                            r1_rsp_valid, busy});
        end
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        total++;
        if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
        do_reset();
        @(negedge clk);
        total++;
        if (err_orphan !== 1'b0) begin bad++; $display("FAIL orphan_clear got=%b exp=0", err_orphan); end
    endtask

    task automatic test_tag_full();
        int acc;
        do_reset();
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            b_r0_valid = 1'b1; b_r1_valid = 1'b1;
            @(negedge clk);
            if (b_r0_ready) acc++;
            if (b_r1_ready) acc++;
            tick();
        end
        total++;
        if (acc != 32) begin bad++; $display("FAIL tag_accepts got=%0d exp=32", acc); end
        b_out_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({b_r0_ready, b_r1_ready} !== 2'b00) begin
            bad++; $display("FAIL tag_no_bypass got=%b%b exp=00", b_r0_ready, b_r1_ready);
        end
        tick();
        b_out_valid = 1'b0;
        @(negedge clk);
        total++;
        if ((b_r0_ready ^ b_r1_ready) !== 1'b1) begin
            bad++; $display("FAIL tag_release got=%b%b exp=one ready", b_r0_ready, b_r1_ready);
        end
        tick();
        @(negedge clk);
        total++;
        if ({b_r0_ready, b_r1_ready} !== 2'b00) begin
            bad++; $display("FAIL tag_refull got=%b%b exp=00", b_r0_ready, b_r1_ready);
        end
        b_r0_valid = 1'b0; b_r1_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; inj_valid = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0; r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
        r0_x = '0; r0_y = '0; r1_x = '0; r1_y = '0;
        b_r0_valid = 1'b0; b_r1_valid = 1'b0; b_rsp_ready = 1'b1; b_out_valid = 1'b0;
        big_p = 512'h1234;
        test_reset();
        test_single();
        test_alternate();
        test_credit();
        test_backpressure();
        test_reset_mid();
        test_tag_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
